timer_arbiter: RTL

- Shares one prescaled countdown timer among NUM_REQ requesters, e.g. I2C transaction watchdogs, sensor power-up delays and poll intervals in the i2c_pipeline.
- Requesters ask for a timeout of N ticks. The block grants the timer round-robin, counts the duration, and pulses done to the owner.
- An owner cancels a timeout by dropping its request.
- Sits between the I2C sequencers and the clock domain's shared timing resource.

---
 rtl/timer_pkg.sv | 15 +
 rtl/rr_pick.sv | 33 +++
 rtl/timer_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and defaults for the round-robin shared countdown timer.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int TICKS_PER_MS_24MHZ = 24000;
   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_DUR_W          = 16;
   localparam int DEF_TICK_DIV       = TICKS_PER_MS_24MHZ;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick
   import timer_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   idx
);

   logic found;
   int   cand;

   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      cand   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!found && req[cand]) begin
            found        = 1'b1;
            onehot[cand] = 1'b1;
            idx          = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/timer_arbiter.sv
// One prescaled countdown timer shared round-robin among NUM_REQ requesters.
module timer_arbiter
   import timer_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int DUR_W    = DEF_DUR_W,
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*DUR_W-1:0] duration,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done,
   output logic                     busy,
   output logic [DUR_W-1:0]         remaining
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   owner;
   logic [PRE_W-1:0]   prescaler;
   logic [NUM_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_idx;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
   endfunction

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   // Abort and cancel both drop straight back to IDLE without a done pulse;
   // only cancel advances the pointer, so an enable abort re-grants the same owner.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         done      <= '0;
         busy      <= 1'b0;
         remaining <= '0;
         prescaler <= '0;
         ptr       <= '0;
         owner     <= '0;
      end else begin
         done <= '0;
         case (state)
            IDLE: begin
               if (enable && (req != '0)) begin
                  grant     <= pick_onehot;
                  owner     <= pick_idx;
                  remaining <= duration[pick_idx*DUR_W +: DUR_W];
                  prescaler <= '0;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (!enable) begin
                  grant     <= '0;
                  busy      <= 1'b0;
                  remaining <= '0;
                  state     <= IDLE;
               end else if (!req[owner]) begin
                  grant     <= '0;
                  busy      <= 1'b0;
                  remaining <= '0;
                  ptr       <= next_idx(owner);
                  state     <= IDLE;
               end else if (remaining == '0) begin
                  done  <= grant;
                  grant <= '0;
                  state <= DONE;
               end else if (prescaler == PRE_W'(TICK_DIV - 1)) begin
                  prescaler <= '0;
                  remaining <= remaining - DUR_W'(1);
               end else begin
                  prescaler <= prescaler + PRE_W'(1);
               end
            end
            DONE: begin
               ptr   <= next_idx(owner);
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               grant     <= '0;
               busy      <= 1'b0;
               remaining <= '0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
